// File: rtl/cla_addsub_pipe_pkg.sv
// rtl/cla_addsub_pipe_pkg.sv - opcode encodings and carry-in helpers for the CLA add/sub pipe
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  function automatic logic is_sub(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

  // Carry into bit 0: SBB treats cin as not-borrow, so it feeds straight in like ADC.
  function automatic logic carry_in(input logic [1:0] op, input logic cin);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_ADC:  c = cin;
      OP_SUB:  c = 1'b1;
      default: c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// rtl/cla_addsub_pipe_if.sv - operand/result stream bundle for the CLA add/sub pipe
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_op, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

endinterface

// File: rtl/cla_addsub_pipe_group4.sv
// rtl/cla_addsub_pipe_group4.sv - combinational 4-bit carry-lookahead group
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       pg,
  output logic       gg
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign pg   = &w_p;
  assign gg   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign cout = gg | (pg & cin);
  assign sum  = w_p ^ w_c;

endmodule

// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - pipelined CLA adder/subtractor, one SEG-bit segment per stage
module cla_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  cla_addsub_pipe_if.slave  bus
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / 4;
  localparam int L   = STAGES - 1;

  if (WIDTH % (4 * STAGES) != 0) begin : g_param_check
    $error("cla_addsub_pipe: WIDTH must be a multiple of 4*STAGES");
  end

  logic [STAGES-1:0]            r_vld;
  logic [STAGES-1:0][WIDTH-1:0] r_a;
  logic [STAGES-1:0][WIDTH-1:0] r_b;
  logic [STAGES-1:0][WIDTH-1:0] r_sum;
  logic [STAGES-1:0]            r_c;
  logic                         r_ovf;
  logic                         r_zero;

  // Stage inputs: stage 0 reads the bus, stage k reads the registers of stage k-1.
  logic [STAGES-1:0]            w_in_vld;
  logic [STAGES-1:0][WIDTH-1:0] w_in_a;
  logic [STAGES-1:0][WIDTH-1:0] w_in_b;
  logic [STAGES-1:0][WIDTH-1:0] w_in_sum;
  logic [STAGES-1:0]            w_in_c;
  logic [STAGES-1:0][WIDTH-1:0] w_nx_sum;
  logic [STAGES-1:0]            w_nx_c;

  logic w_en;
  logic w_msb_c;
  logic w_ovf;
  logic w_zero;
  logic w_unused_ops;

  assign w_en = bus.out_ready | ~r_vld[L];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [NG:0]      w_gc;
    logic [SEG-1:0]   w_seg;
    logic [NG-1:0]    w_pg;
    logic [NG-1:0]    w_gg;
    logic [WIDTH-1:0] w_seg_ext;
    logic             w_unused_pg_gg;

    if (k == 0) begin : g_first
      assign w_in_vld[0] = bus.in_valid;
      assign w_in_a[0]   = bus.in_a;
      assign w_in_b[0]   = is_sub(bus.in_op) ? ~bus.in_b : bus.in_b;
      assign w_in_sum[0] = '0;
      assign w_in_c[0]   = carry_in(bus.in_op, bus.in_cin);
    end else begin : g_next
      assign w_in_vld[k] = r_vld[k-1];
      assign w_in_a[k]   = r_a[k-1];
      assign w_in_b[k]   = r_b[k-1];
      assign w_in_sum[k] = r_sum[k-1];
      assign w_in_c[k]   = r_c[k-1];
    end

    assign w_gc[0] = w_in_c[k];

    for (genvar g = 0; g < NG; g++) begin : g_grp
      cla_group4 u_grp (
        .a    (w_in_a[k][k*SEG + 4*g +: 4]),
        .b    (w_in_b[k][k*SEG + 4*g +: 4]),
        .cin  (w_gc[g]),
        .sum  (w_seg[4*g +: 4]),
        .cout (w_gc[g+1]),
        .pg   (w_pg[g]),
        .gg   (w_gg[g])
      );
    end

    // Lower segments are already in w_in_sum; upper bits are still zero there.
    assign w_seg_ext      = WIDTH'(w_seg);
    assign w_nx_sum[k]    = w_in_sum[k] | (w_seg_ext << (k * SEG));
    assign w_nx_c[k]      = w_gc[NG];
    assign w_unused_pg_gg = ^{w_pg, w_gg};
  end

  // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
  assign w_msb_c = w_in_a[L][WIDTH-1] ^ w_in_b[L][WIDTH-1] ^ w_nx_sum[L][WIDTH-1];
  assign w_ovf   = w_msb_c ^ w_nx_c[L];
  assign w_zero  = ~|w_nx_sum[L];

  assign w_unused_ops = ^{r_a[L], r_b[L], w_in_a, w_in_b};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_c    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_en) begin
      r_vld  <= w_in_vld;
      r_a    <= w_in_a;
      r_b    <= w_in_b;
      r_sum  <= w_nx_sum;
      r_c    <= w_nx_c;
      r_ovf  <= w_ovf;
      r_zero <= w_zero;
    end
  end

  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_vld[L];
  assign bus.out_sum   = r_sum[L];
  assign bus.out_cout  = r_c[L];
  assign bus.out_ovf   = r_ovf;
  assign bus.out_zero  = r_zero;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb/tb_cla_addsub_pipe.sv - directed and scoreboarded checks for cla_addsub_pipe
module tb_cla_addsub_pipe;
  import alu_pkg::*;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
  localparam int NVEC   = 13;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cla_addsub_pipe_if #(.WIDTH(WIDTH)) bus ();

  cla_addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_cons = 0;
  int   first_cons = -1;
  int   last_cons = -1;
  bit   mon_en = 1'b0;
  res_t sb[$];
  vec_t vecs[NVEC];

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [1:0] op, input logic cin);
    logic [15:0] bb;
    logic        c0;
    logic [16:0] t;
    res_t        r;
    bb = op[1] ? ~b : b;
    case (op)
      2'b00:   c0 = 1'b0;
      2'b01:   c0 = cin;
      2'b10:   c0 = 1'b1;
      default: c0 = cin;
    endcase
    t      = {1'b0, a} + {1'b0, bb} + {16'd0, c0};
    r.sum  = t[15:0];
    r.cout = t[16];
    r.ovf  = (a[15] == bb[15]) && (r.sum[15] != a[15]);
    r.zero = (r.sum == 16'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cycle();
    res_t e;
    @(negedge clk);
    if (mon_en) begin
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("stream_sum", 32'(bus.out_sum), 32'(e.sum));
          chk("stream_cout", 32'(bus.out_cout), 32'(e.cout));
          chk("stream_ovf", 32'(bus.out_ovf), 32'(e.ovf));
          chk("stream_zero", 32'(bus.out_zero), 32'(e.zero));
        end
        n_cons++;
        if (first_cons < 0) first_cons = cyc;
        last_cons = cyc;
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(bus.in_a, bus.in_b, bus.in_op, bus.in_cin));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] op, input logic cin);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_cin   = cin;
  endtask

  task automatic send_and_check(input string tag, input vec_t v);
    int lat;
    drive(v.a, v.b, v.op, v.cin);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    cycle();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 10) begin
      cycle();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(STAGES - 1));
    chk({tag, "_sum"}, 32'(bus.out_sum), 32'(v.sum));
    chk({tag, "_cout"}, 32'(bus.out_cout), 32'(v.cout));
    chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(v.ovf));
    chk({tag, "_zero"}, 32'(bus.out_zero), 32'(v.zero));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s_sum;
    logic        s_cout, s_ovf, s_zero;
    int          base;
    int          n;
    vec_t        v;

    //           a         b         op      cin   sum       cout  ovf   zero
    vecs[0]  = '{16'h7FFF, 16'h0001, OP_ADD, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, OP_ADD, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{16'h00FF, 16'h0000, OP_ADC, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'h0005, 16'h0007, OP_SUB, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'h0010, 16'h0001, OP_SBB, 1'b0, 16'h000E, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{16'h8000, 16'h0001, OP_SUB, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{16'hFFFF, 16'h0000, OP_ADD, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{16'h1234, 16'h1234, OP_SUB, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{16'hFFFF, 16'hFFFF, OP_ADC, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{16'h0000, 16'h0000, OP_SBB, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{16'h4000, 16'h4000, OP_ADD, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{16'h7FFF, 16'h8000, OP_SUB, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{16'h0FFF, 16'h0001, OP_ADD, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = OP_ADD;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    cycle();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_out_cout", 32'(bus.out_cout), 32'd0);
    chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    chk("rst_out_zero", 32'(bus.out_zero), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    cycle();

    for (int i = 0; i < NVEC; i++)
      send_and_check($sformatf("v%0d", i), vecs[i]);
    cycle();

    // Back-to-back stream with out_ready held high.
    mon_en     = 1'b1;
    base       = n_cons;
    first_cons = -1;
    for (int i = 0; i < 8; i++) begin
      drive(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom));
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      cycle();
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("stream_drained", 32'(sb.size()), 32'd0);
    chk("stream_count", 32'(n_cons - base), 32'd8);
    chk("stream_consecutive", 32'(last_cons - first_cons), 32'd7);

    // Fill the pipe with out_ready low, stall, then release.
    bus.out_ready = 1'b0;
    base          = n_cons;
    for (int i = 0; i < STAGES; i++) begin
      drive(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom));
      cycle();
    end
    drive(16'hA5A5, 16'h0F0F, OP_SUB, 1'b0);
    chk("bp_full_valid", 32'(bus.out_valid), 32'd1);
    s_sum  = bus.out_sum;
    s_cout = bus.out_cout;
    s_ovf  = bus.out_ovf;
    s_zero = bus.out_zero;
    for (int s = 0; s < 3; s++) begin
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_sum_stable", 32'(bus.out_sum), 32'(s_sum));
      chk("bp_flags_stable", 32'({bus.out_cout, bus.out_ovf, bus.out_zero}),
          32'({s_cout, s_ovf, s_zero}));
      cycle();
    end
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("bp_drained", 32'(sb.size()), 32'd0);
    chk("bp_count", 32'(n_cons - base), 32'(STAGES + 1));

    // Reset with three beats in flight.
    mon_en = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      drive(16'h1111 * 16'(i + 1), 16'h0101, OP_ADD, 1'b0);
      cycle();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("mid_rst_out_flags", 32'({bus.out_cout, bus.out_ovf, bus.out_zero}), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    v = '{16'h1234, 16'h4321, OP_ADD, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    send_and_check("post_rst", v);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
